// File: rtl/riscv_v_shift_seq_if.sv
// Bundle between the vector shift sequencer and its neighbours:
// micro-op issue, VRF read port, shifter drive and writeback.
interface riscv_v_shift_seq_if #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_BYTES  = DATA_WIDTH / 8,
    parameter int NUM_OSIZES = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_is_left;
    logic                  in_is_arith;
    logic [NUM_OSIZES-1:0] in_osize_vector;
    logic [1:0]            in_lmul_log2;
    logic [4:0]            in_vd;
    logic [4:0]            in_vs2;
    logic [4:0]            in_vs1;
    logic                  in_use_scalar;
    logic [7:0]            in_scalar;

    logic                  rf_rd_en;
    logic [4:0]            rf_rd_addr_a;
    logic [4:0]            rf_rd_addr_b;
    logic [DATA_WIDTH-1:0] rf_rd_data_a;
    logic [DATA_WIDTH-1:0] rf_rd_data_b;

    logic                  shf_is_shift;
    logic                  shf_is_left;
    logic                  shf_is_arith;
    logic [NUM_OSIZES-1:0] shf_osize_vector;
    logic [NUM_OSIZES-1:0] shf_is_greater_osize_vector;
    logic [DATA_WIDTH-1:0] shf_data_a;
    logic [DATA_WIDTH-1:0] shf_data_b;
    logic [NUM_BYTES-1:0]  shf_merge;
    logic [DATA_WIDTH-1:0] shf_result;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_last;

    modport master (
        input  in_valid, in_is_left, in_is_arith, in_osize_vector,
        input  in_lmul_log2, in_vd, in_vs2, in_vs1,
        input  in_use_scalar, in_scalar,
        output in_ready,
        output rf_rd_en, rf_rd_addr_a, rf_rd_addr_b,
        input  rf_rd_data_a, rf_rd_data_b,
        output shf_is_shift, shf_is_left, shf_is_arith,
        output shf_osize_vector, shf_is_greater_osize_vector,
        output shf_data_a, shf_data_b, shf_merge,
        input  shf_result,
        output wb_valid, wb_addr, wb_data, wb_last,
        input  wb_ready
    );

    modport slave (
        output in_valid, in_is_left, in_is_arith, in_osize_vector,
        output in_lmul_log2, in_vd, in_vs2, in_vs1,
        output in_use_scalar, in_scalar,
        input  in_ready,
        input  rf_rd_en, rf_rd_addr_a, rf_rd_addr_b,
        output rf_rd_data_a, rf_rd_data_b,
        input  shf_is_shift, shf_is_left, shf_is_arith,
        input  shf_osize_vector, shf_is_greater_osize_vector,
        input  shf_data_a, shf_data_b, shf_merge,
        output shf_result,
        input  wb_valid, wb_addr, wb_data, wb_last,
        output wb_ready
    );
endinterface

// File: rtl/riscv_v_shift_seq.sv
// Vector shift sequencer: walks an LMUL group through VRF read, shift, writeback.
// Optional RISCV_V_SHIFT_SCALAR_EN: shift amount broadcast from in_scalar.
module riscv_v_shift_seq #(
    parameter int DATA_WIDTH = 128
) (
    input logic                 clk,
    input logic                 rst,
    riscv_v_shift_seq_if.master bus
);
    localparam int NUM_BYTES     = DATA_WIDTH / 8;
    localparam int NUM_OSIZES    = 5;
    localparam int MAX_LMUL_LOG2 = 3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t                   state_q, state_d;
    logic [MAX_LMUL_LOG2-1:0] g_q, g_d;
    logic [MAX_LMUL_LOG2-1:0] last_idx;
    logic [1:0]               lmul_q;
    logic [4:0]               vd_q, vs1_q, vs2_q;
    logic                     is_left_q, is_arith_q;
    logic [2:0]               k_q, k_in;
    logic [NUM_OSIZES-1:0]    osize_q, greater_q;
    logic [NUM_BYTES-1:0]     merge_q;
    logic [DATA_WIDTH-1:0]    wb_data_q;
    logic [DATA_WIDTH-1:0]    amt_src;
    logic                     accept, wb_fire, is_last;

    function automatic logic [2:0] osize_index(input logic [NUM_OSIZES-1:0] v);
        case (v)
            5'b00001: osize_index = 3'd0;
            5'b00010: osize_index = 3'd1;
            5'b00100: osize_index = 3'd2;
            5'b01000: osize_index = 3'd3;
            5'b10000: osize_index = 3'd4;
            default:  osize_index = 3'd0;
        endcase
    endfunction

    function automatic logic [NUM_BYTES-1:0] merge_of(input logic [2:0] k);
        int mask;
        mask = (1 << k) - 1;
        for (int i = 0; i < NUM_BYTES; i++) begin
            merge_of[i] = (((i + 1) & mask) != 0);
        end
    endfunction

    function automatic logic [NUM_OSIZES-1:0] greater_of(input logic [2:0] k);
        for (int j = 0; j < NUM_OSIZES; j++) begin
            greater_of[j] = (int'(k) >= j);
        end
    endfunction

    assign k_in     = osize_index(bus.in_osize_vector);
    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign last_idx = MAX_LMUL_LOG2'((4'd1 << lmul_q) - 4'd1);
    assign is_last  = (g_q == last_idx);
    assign wb_fire  = (state_q == WB) && bus.wb_ready;

`ifdef RISCV_V_SHIFT_SCALAR_EN
    logic                  use_scalar_q;
    logic [7:0]            scalar_q;
    logic [DATA_WIDTH-1:0] scalar_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            use_scalar_q <= 1'b0;
            scalar_q     <= 8'h00;
        end else if (accept) begin
            use_scalar_q <= bus.in_use_scalar;
            scalar_q     <= bus.in_scalar;
        end
    end

    // Scalar amount lands in the lowest byte of each element.
    always_comb begin
        scalar_vec = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if ((i & ((1 << k_q) - 1)) == 0) begin
                scalar_vec[i*8 +: 8] = scalar_q;
            end
        end
    end

    assign amt_src = use_scalar_q ? scalar_vec : bus.rf_rd_data_a;
`else
    logic unused_scalar;
    assign unused_scalar = ^{bus.in_use_scalar, bus.in_scalar};
    assign amt_src       = bus.rf_rd_data_a;
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                    g_d     = '0;
                end
            end
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB: begin
                if (wb_fire) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        state_d = READ;
                        g_d     = g_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            g_q        <= '0;
            lmul_q     <= 2'd0;
            vd_q       <= 5'd0;
            vs1_q      <= 5'd0;
            vs2_q      <= 5'd0;
            is_left_q  <= 1'b0;
            is_arith_q <= 1'b0;
            k_q        <= 3'd0;
            osize_q    <= '0;
            greater_q  <= '0;
            merge_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            if (accept) begin
                lmul_q     <= bus.in_lmul_log2;
                vd_q       <= bus.in_vd;
                vs1_q      <= bus.in_vs1;
                vs2_q      <= bus.in_vs2;
                is_left_q  <= bus.in_is_left;
                is_arith_q <= bus.in_is_arith;
                k_q        <= k_in;
                osize_q    <= NUM_OSIZES'(1) << k_in;
                greater_q  <= greater_of(k_in);
                merge_q    <= merge_of(k_in);
            end
            if (state_q == EXEC) begin
                wb_data_q <= bus.shf_result;
            end
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.rf_rd_en     = (state_q == READ);
    assign bus.rf_rd_addr_a = vs1_q + 5'(g_q);
    assign bus.rf_rd_addr_b = vs2_q + 5'(g_q);

    assign bus.shf_is_shift                = (state_q == EXEC);
    assign bus.shf_is_left                 = is_left_q;
    assign bus.shf_is_arith                = is_arith_q;
    assign bus.shf_osize_vector            = osize_q;
    assign bus.shf_is_greater_osize_vector = greater_q;
    assign bus.shf_merge                   = merge_q;
    assign bus.shf_data_a = (state_q == EXEC) ? amt_src : '0;
    assign bus.shf_data_b = (state_q == EXEC) ? bus.rf_rd_data_b : '0;

    assign bus.wb_valid = (state_q == WB);
    assign bus.wb_addr  = vd_q + 5'(g_q);
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_last  = (state_q == WB) && is_last;
endmodule

// File: tb/tb_riscv_v_shift_seq.sv
// Directed bench for riscv_v_shift_seq with a VRF model and a
// behavioural element shifter; expected values are hand-computed.
module tb_riscv_v_shift_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [127:0] vrf [32];

    riscv_v_shift_seq_if vif ();

    riscv_v_shift_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vif.rf_rd_en) begin
            vif.rf_rd_data_a <= vrf[vif.rf_rd_addr_a];
            vif.rf_rd_data_b <= vrf[vif.rf_rd_addr_b];
        end
    end

    function automatic int kdec(input logic [4:0] v);
        case (v)
            5'b00010: kdec = 1;
            5'b00100: kdec = 2;
            5'b01000: kdec = 3;
            5'b10000: kdec = 4;
            default:  kdec = 0;
        endcase
    endfunction

    function automatic logic [127:0] shifter(input logic [127:0] a,
                                             input logic [127:0] b,
                                             input int k,
                                             input logic left,
                                             input logic arith);
        int w = 8 << k;
        int n = 128 / w;
        int amt;
        logic [127:0] mask, elem, r, res;
        mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        res  = '0;
        for (int e = 0; e < n; e++) begin
            elem = (b >> (e * w)) & mask;
            amt  = int'(a[e*w +: 8]) & (w - 1);
            if (left) begin
                r = (elem << amt) & mask;
            end else begin
                r = elem >> amt;
                if (arith && elem[w-1]) r = r | (mask & ~(mask >> amt));
            end
            res = res | (r << (e * w));
        end
        return res;
    endfunction

    always_comb begin
        vif.shf_result = '0;
        if (vif.shf_is_shift) begin
            vif.shf_result = shifter(vif.shf_data_a, vif.shf_data_b,
                                     kdec(vif.shf_osize_vector),
                                     vif.shf_is_left, vif.shf_is_arith);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic left, input logic arith,
                         input logic [4:0] osize, input logic [1:0] lmul,
                         input logic [4:0] vd, input logic [4:0] vs2,
                         input logic [4:0] vs1, input logic use_s,
                         input logic [7:0] scalar);
        vif.in_valid        = 1'b1;
        vif.in_is_left      = left;
        vif.in_is_arith     = arith;
        vif.in_osize_vector = osize;
        vif.in_lmul_log2    = lmul;
        vif.in_vd           = vd;
        vif.in_vs2          = vs2;
        vif.in_vs1          = vs1;
        vif.in_use_scalar   = use_s;
        vif.in_scalar       = scalar;
        tick();
        vif.in_valid = 1'b0;
    endtask

    logic [4:0] exp_wb [4];

    initial begin
        for (int i = 0; i < 32; i++) vrf[i] = '0;
        vif.in_valid        = 1'b0;
        vif.in_is_left      = 1'b0;
        vif.in_is_arith     = 1'b0;
        vif.in_osize_vector = 5'b00001;
        vif.in_lmul_log2    = 2'd0;
        vif.in_vd           = 5'd0;
        vif.in_vs2          = 5'd0;
        vif.in_vs1          = 5'd0;
        vif.in_use_scalar   = 1'b0;
        vif.in_scalar       = 8'h00;
        vif.wb_ready        = 1'b1;
        vif.rf_rd_data_a    = '0;
        vif.rf_rd_data_b    = '0;
        exp_wb = '{5'd30, 5'd31, 5'd0, 5'd1};

        // reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 128'(vif.in_ready), 128'd1);
        check("rst_rd_en", 128'(vif.rf_rd_en), 128'd0);
        check("rst_wb_valid", 128'(vif.wb_valid), 128'd0);
        check("rst_wb_last", 128'(vif.wb_last), 128'd0);
        check("rst_wb_addr", 128'(vif.wb_addr), 128'd0);
        check("rst_wb_data", vif.wb_data, 128'd0);
        check("rst_merge", 128'(vif.shf_merge), 128'd0);
        check("rst_greater", 128'(vif.shf_is_greater_osize_vector), 128'd0);
        check("rst_is_shift", 128'(vif.shf_is_shift), 128'd0);
        rst = 1'b0;

        // 1: single byte op, logical right by 4
        vrf[2] = {16{8'hF0}};
        vrf[1] = {16{8'h04}};
        issue(1'b0, 1'b0, 5'b00001, 2'd0, 5'd3, 5'd2, 5'd1, 1'b0, 8'h00);
        check("t1_rd_en", 128'(vif.rf_rd_en), 128'd1);
        check("t1_addr_a", 128'(vif.rf_rd_addr_a), 128'd1);
        check("t1_addr_b", 128'(vif.rf_rd_addr_b), 128'd2);
        check("t1_busy", 128'(vif.in_ready), 128'd0);
        tick();
        check("t1_is_shift", 128'(vif.shf_is_shift), 128'd1);
        check("t1_data_b", vif.shf_data_b, {16{8'hF0}});
        tick();
        check("t1_wb_valid", 128'(vif.wb_valid), 128'd1);
        check("t1_wb_addr", 128'(vif.wb_addr), 128'd3);
        check("t1_wb_data", vif.wb_data, {16{8'h0F}});
        check("t1_wb_last", 128'(vif.wb_last), 128'd1);
        tick();
        check("t1_ready_back", 128'(vif.in_ready), 128'd1);
        check("t1_wb_drop", 128'(vif.wb_valid), 128'd0);
        check("t1_shift_off", 128'(vif.shf_is_shift), 128'd0);

        // 2: four-register group wrapping vd past 31
        for (int g = 0; g < 4; g++) begin
            vrf[4+g] = {16{8'h80}};
            vrf[8+g] = {16{8'h01}};
        end
        issue(1'b0, 1'b0, 5'b00001, 2'd2, 5'd30, 5'd4, 5'd8, 1'b0, 8'h00);
        for (int g = 0; g < 4; g++) begin
            check("t2_rd_en", 128'(vif.rf_rd_en), 128'd1);
            check("t2_addr_a", 128'(vif.rf_rd_addr_a), 128'(8 + g));
            check("t2_addr_b", 128'(vif.rf_rd_addr_b), 128'(4 + g));
            check("t2_wb_idle", 128'(vif.wb_valid), 128'd0);
            tick();
            check("t2_exec_nowb", 128'(vif.wb_valid), 128'd0);
            tick();
            check("t2_wb_valid", 128'(vif.wb_valid), 128'd1);
            check("t2_wb_addr", 128'(vif.wb_addr), 128'(exp_wb[g]));
            check("t2_wb_last", 128'(vif.wb_last), 128'(g == 3));
            check("t2_wb_data", vif.wb_data, {16{8'h40}});
            tick();
        end
        check("t2_done", 128'(vif.in_ready), 128'd1);

        // 3: 32-bit arithmetic right by 4
        vrf[10] = {4{32'h8000_0000}};
        vrf[11] = {16{8'h04}};
        issue(1'b0, 1'b1, 5'b00100, 2'd0, 5'd12, 5'd10, 5'd11, 1'b0, 8'h00);
        tick();
        check("t3_merge", 128'(vif.shf_merge), 128'h7777);
        check("t3_greater", 128'(vif.shf_is_greater_osize_vector), 128'b00111);
        tick();
        check("t3_wb_data", vif.wb_data, {4{32'hF800_0000}});
        tick();

        // 4: writeback stall for 5 cycles
        vrf[13] = {16{8'h33}};
        vrf[14] = '0;
        vrf[15] = {16{8'h01}};
        vif.wb_ready = 1'b0;
        issue(1'b0, 1'b0, 5'b00001, 2'd1, 5'd20, 5'd13, 5'd14, 1'b0, 8'h00);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_valid", 128'(vif.wb_valid), 128'd1);
            check("t4_stall_addr", 128'(vif.wb_addr), 128'd20);
            check("t4_stall_data", vif.wb_data, {16{8'h33}});
            check("t4_stall_last", 128'(vif.wb_last), 128'd0);
            check("t4_stall_rd", 128'(vif.rf_rd_en), 128'd0);
            tick();
        end
        vif.wb_ready = 1'b1;
        tick();
        check("t4_resume_rd", 128'(vif.rf_rd_en), 128'd1);
        check("t4_resume_addr_b", 128'(vif.rf_rd_addr_b), 128'd14);
        tick();
        tick();
        check("t4_wb2_addr", 128'(vif.wb_addr), 128'd21);
        check("t4_wb2_last", 128'(vif.wb_last), 128'd1);
        check("t4_wb2_data", vif.wb_data, 128'd0);
        tick();
        check("t4_done", 128'(vif.in_ready), 128'd1);

        // 5: reset in EXEC of the second register of an 8-register group
        vrf[16] = {16{8'h55}};
        vrf[24] = '0;
        issue(1'b1, 1'b0, 5'b00001, 2'd3, 5'd0, 5'd16, 5'd24, 1'b0, 8'h00);
        tick();
        tick();
        tick();
        tick();
        check("t5_in_exec", 128'(vif.shf_is_shift), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_in_ready", 128'(vif.in_ready), 128'd1);
        check("t5_wb_valid", 128'(vif.wb_valid), 128'd0);
        check("t5_rd_en", 128'(vif.rf_rd_en), 128'd0);
        check("t5_addr_a", 128'(vif.rf_rd_addr_a), 128'd0);
        check("t5_addr_b", 128'(vif.rf_rd_addr_b), 128'd0);
        check("t5_is_shift", 128'(vif.shf_is_shift), 128'd0);
        check("t5_is_left", 128'(vif.shf_is_left), 128'd0);
        check("t5_osize", 128'(vif.shf_osize_vector), 128'd0);
        check("t5_merge", 128'(vif.shf_merge), 128'd0);
        check("t5_wb_addr", 128'(vif.wb_addr), 128'd0);
        check("t5_wb_data", vif.wb_data, 128'd0);
        check("t5_wb_last", 128'(vif.wb_last), 128'd0);
        issue(1'b0, 1'b0, 5'b00001, 2'd0, 5'd5, 5'd16, 5'd24, 1'b0, 8'h00);
        tick();
        tick();
        check("t5_fresh_addr", 128'(vif.wb_addr), 128'd5);
        check("t5_fresh_data", vif.wb_data, {16{8'h55}});
        check("t5_fresh_last", 128'(vif.wb_last), 128'd1);
        tick();
        check("t5_fresh_done", 128'(vif.in_ready), 128'd1);

        // 6: scalar shift amount, 16-bit left
        vrf[17] = {8{16'h0001}};
        vrf[18] = {8{16'h0002}};
        issue(1'b1, 1'b0, 5'b00010, 2'd0, 5'd6, 5'd17, 5'd18, 1'b1, 8'd3);
        tick();
        check("t6_merge", 128'(vif.shf_merge), 128'h5555);
`ifdef RISCV_V_SHIFT_SCALAR_EN
        check("t6_data_a", vif.shf_data_a, {8{16'h0003}});
        tick();
        check("t6_wb_data", vif.wb_data, {8{16'h0008}});
`else
        check("t6_data_a", vif.shf_data_a, {8{16'h0002}});
        tick();
        check("t6_wb_data", vif.wb_data, {8{16'h0004}});
`endif
        tick();

        // 7: non-one-hot osize falls back to byte elements
        vrf[19] = '0;
        issue(1'b0, 1'b0, 5'b00110, 2'd0, 5'd7, 5'd17, 5'd19, 1'b0, 8'h00);
        tick();
        check("t7_merge", 128'(vif.shf_merge), 128'd0);
        check("t7_greater", 128'(vif.shf_is_greater_osize_vector), 128'b00001);
        tick();
        check("t7_wb_data", vif.wb_data, {8{16'h0001}});
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
